// File: rtl/branch_cond_unit.sv
// branch_cond_unit: resolves B / B.cond / CBZ / CBNZ in decode.
// A taken branch issues a registered redirect to fetch. The unit flushes
// IF/ID on the first redirect cycle and stalls decode until fetch accepts.
// It also keeps saturating counts of evaluated and taken branches.
module branch_cond_unit #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic [1:0]        br_kind,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              rt_is_zero,
  input  logic [3:0]        flags_q,
  input  logic              ex_setflags,
  input  logic              ex_n,
  input  logic              ex_z,
  input  logic              ex_v,
  input  logic              ex_c,
  input  logic              fetch_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              stall,
  output logic [CNT_W-1:0]  br_total,
  output logic [CNT_W-1:0]  br_taken
);

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                first_q, first_d;
  logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]    br_total_q, br_total_d;
  logic [CNT_W-1:0]    br_taken_q, br_taken_d;

  logic                n_eff, z_eff, v_eff, c_eff;
  logic                gt;
  logic                cond_true;
  logic                taken;

  // Effective flags: an EX instruction writing flags this cycle overrides flags_q
  always_comb begin
    n_eff = ex_setflags ? ex_n : flags_q[0];
    z_eff = ex_setflags ? ex_z : flags_q[1];
    v_eff = ex_setflags ? ex_v : flags_q[2];
    c_eff = ex_setflags ? ex_c : flags_q[3];
  end

  // ARM condition-code decode and per-kind taken decision
  always_comb begin
    gt        = ~z_eff & (n_eff == v_eff);
    cond_true = 1'b1;
    unique case (br_cond)
      4'h0: cond_true = z_eff;
      4'h1: cond_true = ~z_eff;
      4'h2: cond_true = c_eff;
      4'h3: cond_true = ~c_eff;
      4'h4: cond_true = n_eff;
      4'h5: cond_true = ~n_eff;
      4'h6: cond_true = v_eff;
      4'h7: cond_true = ~v_eff;
      4'h8: cond_true = c_eff & ~z_eff;
      4'h9: cond_true = ~(c_eff & ~z_eff);
      4'hA: cond_true = (n_eff == v_eff);
      4'hB: cond_true = (n_eff != v_eff);
      4'hC: cond_true = gt;
      4'hD: cond_true = ~gt;
      default: cond_true = 1'b1;
    endcase
    unique case (br_kind)
      2'b00:   taken = 1'b1;
      2'b01:   taken = cond_true;
      2'b10:   taken = rt_is_zero;
      default: taken = ~rt_is_zero;
    endcase
  end

  // Next-state, redirect target latch and saturating statistics
  always_comb begin
    state_d       = state_q;
    first_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    br_total_d    = br_total_q;
    br_taken_d    = br_taken_q;
    unique case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (br_total_q != '1) br_total_d = br_total_q + CNT_ONE;
          if (taken) begin
            if (br_taken_q != '1) br_taken_d = br_taken_q + CNT_ONE;
            redirect_pc_d = br_target;
            first_d       = 1'b1;
            state_d       = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        // Decode instructions here are wrong-path: br_valid is not looked at.
        if (fetch_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      first_q       <= 1'b0;
      redirect_pc_q <= '0;
      br_total_q    <= '0;
      br_taken_q    <= '0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      redirect_pc_q <= redirect_pc_d;
      br_total_q    <= br_total_d;
      br_taken_q    <= br_taken_d;
    end
  end

  // Outputs decode purely from registered state so reset clears them at once
  always_comb begin
    redirect_valid = (state_q == REDIRECT);
    stall          = (state_q == REDIRECT);
    flush          = (state_q == REDIRECT) & first_q;
    redirect_pc    = redirect_pc_q;
    br_total       = br_total_q;
    br_taken       = br_taken_q;
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: vector table plus hand sequences,
// with expected outputs queued at drive time and popped after the edge.
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  br_kind = '0;
  logic [3:0]  br_cond = '0;
  logic [63:0] br_target = '0;
  logic        rt_is_zero = 1'b0;
  logic [3:0]  flags_q = '0;
  logic        ex_setflags = 1'b0;
  logic        ex_n = 1'b0, ex_z = 1'b0, ex_v = 1'b0, ex_c = 1'b0;
  logic        fetch_ready = 1'b0;

  logic        redirect_valid, flush, stall;
  logic [63:0] redirect_pc;
  logic [15:0] br_total, br_taken;

  logic        s_rv, s_fl, s_st;
  logic [63:0] s_pc;
  logic [1:0]  s_tot, s_tak;

  branch_cond_unit #(.ADDR_W(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_kind(br_kind),
    .br_cond(br_cond), .br_target(br_target), .rt_is_zero(rt_is_zero),
    .flags_q(flags_q), .ex_setflags(ex_setflags), .ex_n(ex_n), .ex_z(ex_z),
    .ex_v(ex_v), .ex_c(ex_c), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .stall(stall), .br_total(br_total), .br_taken(br_taken)
  );

  branch_cond_unit #(.ADDR_W(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_kind(br_kind),
    .br_cond(br_cond), .br_target(br_target), .rt_is_zero(rt_is_zero),
    .flags_q(flags_q), .ex_setflags(ex_setflags), .ex_n(ex_n), .ex_z(ex_z),
    .ex_v(ex_v), .ex_c(ex_c), .fetch_ready(fetch_ready),
    .redirect_valid(s_rv), .redirect_pc(s_pc),
    .flush(s_fl), .stall(s_st), .br_total(s_tot), .br_taken(s_tak)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  cond;
    logic [3:0]  flags;   // {C,V,Z,N}
    logic        sf;
    logic [3:0]  ex;      // {c,v,z,n}
    logic        rtz;
    logic [63:0] tgt;
    bit          tk;
  } vec_t;

  typedef struct {
    logic        rv, fl, st;
    logic [63:0] pc;
    logic [15:0] tot, tak;
    logic [1:0]  stot, stak;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[26];

  int n_checks = 0;
  int n_fail   = 0;

  int          m_tot = 0, m_tak = 0;
  bit          m_redir = 0, m_first = 0;
  logic [63:0] m_pc = '0;

  function automatic vec_t mk(logic [1:0] kind, logic [3:0] cond, logic [3:0] flags,
                              logic sf, logic [3:0] ex, logic rtz, logic [63:0] tgt, bit tk);
    vec_t v;
    v.kind = kind; v.cond = cond; v.flags = flags; v.sf = sf;
    v.ex = ex; v.rtz = rtz; v.tgt = tgt; v.tk = tk;
    return v;
  endfunction

  function automatic logic [15:0] sat16(int v);
    logic [31:0] w;
    w = v;
    return (v > 65535) ? 16'hFFFF : w[15:0];
  endfunction

  function automatic logic [1:0] sat2(int v);
    logic [31:0] w;
    w = v;
    return (v > 3) ? 2'd3 : w[1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_br(input vec_t v);
    br_kind     = v.kind;
    br_cond     = v.cond;
    flags_q     = v.flags;
    ex_setflags = v.sf;
    {ex_c, ex_v, ex_z, ex_n} = v.ex;
    rt_is_zero  = v.rtz;
    br_target   = v.tgt;
  endtask

  // Drive one cycle, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic v, input bit tk, input logic fr, input string tag);
    exp_t e;
    br_valid    = v;
    fetch_ready = fr;
    if (!m_redir) begin
      if (v) begin
        m_tot++;
        if (tk) begin
          m_tak++;
          m_pc    = br_target;
          m_redir = 1;
          m_first = 1;
        end
      end
    end else begin
      m_first = 0;
      if (fr) m_redir = 0;
    end
    e.rv = m_redir; e.fl = m_redir && m_first; e.st = m_redir; e.pc = m_pc;
    e.tot = sat16(m_tot); e.tak = sat16(m_tak);
    e.stot = sat2(m_tot); e.stak = sat2(m_tak); e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s.scoreboard: got empty queue, want one entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".redirect_valid"}, {63'd0, redirect_valid}, {63'd0, e.rv});
      chk({e.tag, ".flush"},          {63'd0, flush},          {63'd0, e.fl});
      chk({e.tag, ".stall"},          {63'd0, stall},          {63'd0, e.st});
      chk({e.tag, ".redirect_pc"},    redirect_pc,             e.pc);
      chk({e.tag, ".br_total"},       {48'd0, br_total},       {48'd0, e.tot});
      chk({e.tag, ".br_taken"},       {48'd0, br_taken},       {48'd0, e.tak});
      chk({e.tag, ".sat_total"},      {62'd0, s_tot},          {62'd0, e.stot});
      chk({e.tag, ".sat_taken"},      {62'd0, s_tak},          {62'd0, e.stak});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".redirect_valid"}, {63'd0, redirect_valid}, 64'd0);
    chk({tag, ".flush"},          {63'd0, flush},          64'd0);
    chk({tag, ".stall"},          {63'd0, stall},          64'd0);
    chk({tag, ".redirect_pc"},    redirect_pc,             64'd0);
    chk({tag, ".br_total"},       {48'd0, br_total},       64'd0);
    chk({tag, ".br_taken"},       {48'd0, br_taken},       64'd0);
    chk({tag, ".sat_rv"},         {63'd0, s_rv},           64'd0);
    chk({tag, ".sat_total"},      {62'd0, s_tot},          64'd0);
  endtask

  initial begin
    //            kind  cond   flags    sf  ex       rtz  target     taken
    vt[0]  = mk(2'd1, 4'h0, 4'b0010, 0, 4'b0000, 0, 64'h40,  1); // EQ, Z=1
    vt[1]  = mk(2'd1, 4'h0, 4'b0000, 0, 4'b0000, 0, 64'h44,  0); // EQ, Z=0
    vt[2]  = mk(2'd1, 4'h1, 4'b0000, 0, 4'b0000, 0, 64'h80,  1); // NE
    vt[3]  = mk(2'd1, 4'h2, 4'b1000, 0, 4'b0000, 0, 64'h88,  1); // HS
    vt[4]  = mk(2'd1, 4'h3, 4'b1000, 0, 4'b0000, 0, 64'h8c,  0); // LO
    vt[5]  = mk(2'd1, 4'h4, 4'b0001, 0, 4'b0000, 0, 64'h90,  1); // MI
    vt[6]  = mk(2'd1, 4'h5, 4'b0001, 0, 4'b0000, 0, 64'h94,  0); // PL
    vt[7]  = mk(2'd1, 4'h6, 4'b0100, 0, 4'b0000, 0, 64'h98,  1); // VS
    vt[8]  = mk(2'd1, 4'h7, 4'b0100, 0, 4'b0000, 0, 64'h9c,  0); // VC
    vt[9]  = mk(2'd1, 4'h8, 4'b1000, 0, 4'b0000, 0, 64'ha0,  1); // HI
    vt[10] = mk(2'd1, 4'h8, 4'b1010, 0, 4'b0000, 0, 64'ha4,  0); // HI, Z set
    vt[11] = mk(2'd1, 4'h9, 4'b1010, 0, 4'b0000, 0, 64'ha8,  1); // LS
    vt[12] = mk(2'd1, 4'hA, 4'b0101, 0, 4'b0000, 0, 64'hac,  1); // GE, N=V=1
    vt[13] = mk(2'd1, 4'hB, 4'b0000, 1, 4'b0001, 0, 64'hb0,  1); // LT via bypass
    vt[14] = mk(2'd1, 4'hB, 4'b0000, 0, 4'b0001, 0, 64'hb4,  0); // LT, no bypass
    vt[15] = mk(2'd1, 4'hC, 4'b0000, 0, 4'b0000, 0, 64'hb8,  1); // GT
    vt[16] = mk(2'd1, 4'hD, 4'b0000, 0, 4'b0000, 0, 64'hbc,  0); // LE false
    vt[17] = mk(2'd1, 4'hD, 4'b0010, 0, 4'b0000, 0, 64'hc0,  1); // LE via Z
    vt[18] = mk(2'd1, 4'hE, 4'b0000, 0, 4'b0000, 0, 64'hc4,  1); // AL
    vt[19] = mk(2'd1, 4'hF, 4'b0000, 0, 4'b0000, 0, 64'hc8,  1); // NV
    vt[20] = mk(2'd2, 4'h0, 4'b0000, 0, 4'b0000, 0, 64'hcc,  0); // CBZ, rt!=0
    vt[21] = mk(2'd3, 4'h0, 4'b0000, 0, 4'b0000, 0, 64'h100, 1); // CBNZ, rt!=0
    vt[22] = mk(2'd2, 4'h0, 4'b0000, 0, 4'b0000, 1, 64'h104, 1); // CBZ, rt==0
    vt[23] = mk(2'd0, 4'h1, 4'b0010, 0, 4'b0000, 0, 64'h108, 1); // B ignores cond
    vt[24] = mk(2'd1, 4'h0, 4'b0010, 1, 4'b0000, 0, 64'h10c, 0); // bypass overrides Z
    vt[25] = mk(2'd3, 4'h0, 4'b0000, 0, 4'b0000, 1, 64'h110, 0); // CBNZ, rt==0

    // Reset held with random inputs: everything stays zero
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      br_valid = 1'b1;
      br_kind = 2'($urandom); br_cond = 4'($urandom);
      br_target = {32'($urandom), 32'($urandom)};
      rt_is_zero = 1'($urandom); flags_q = 4'($urandom);
      ex_setflags = 1'($urandom); fetch_ready = 1'($urandom);
      @(negedge clk);
      chk_all_zero("reset_hold");
    end
    @(posedge clk); #1;
    br_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, "post_reset_idle");

    // Table of single-branch vectors, fetch always ready
    for (int unsigned i = 0; i < 26; i++) begin
      set_br(vt[i]);
      step(1'b1, vt[i].tk, 1'b1, $sformatf("vec%0d", i));
      if (vt[i].tk) step(1'b0, 1'b0, 1'b1, $sformatf("vec%0d_ret", i));
    end

    // Backpressure: fetch stalls 3 cycles; wrong-path br_valid pulses ignored
    set_br(mk(2'd0, 4'h0, 4'b0000, 0, 4'b0000, 0, 64'h1234, 1));
    step(1'b1, 1'b1, 1'b0, "bp_issue");
    br_target = 64'hdead_beef;
    step(1'b1, 1'b1, 1'b0, "bp_wait1");
    step(1'b0, 1'b0, 1'b0, "bp_wait2");
    step(1'b1, 1'b1, 1'b0, "bp_wait3");
    step(1'b1, 1'b1, 1'b1, "bp_accept");
    step(1'b0, 1'b0, 1'b1, "bp_idle");

    // Reset asserted mid-REDIRECT clears outputs without a clock edge
    set_br(mk(2'd0, 4'h0, 4'b0000, 0, 4'b0000, 0, 64'h2000, 1));
    step(1'b1, 1'b1, 1'b0, "rst_mid_issue");
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid_async");
    m_tot = 0; m_tak = 0; m_redir = 0; m_first = 0; m_pc = '0;
    @(posedge clk); #1;
    br_valid = 1'b0;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, "rst_mid_release");

    // Five taken branches: CNT_W=2 instance saturates at 3
    for (int i = 0; i < 5; i++) begin
      set_br(mk(2'd0, 4'h0, 4'b0000, 0, 4'b0000, 0, 64'h3000 + 64'(i * 4), 1));
      step(1'b1, 1'b1, 1'b1, $sformatf("sat_br%0d", i));
      step(1'b0, 1'b0, 1'b1, $sformatf("sat_ret%0d", i));
    end
    chk("sat_final_total", {62'd0, s_tot}, 64'd3);
    chk("sat_final_taken", {62'd0, s_tak}, 64'd3);
    chk("wide_final_total", {48'd0, br_total}, 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
